// File: rtl/cart_save_upload.sv
// Cartridge save-RAM upload to the HPS: byte reads through ioctl, dirty tracking, upload requests.
// Ports: clk_sys/reset_n; ioctl_* HPS side; mem_* save-RAM side; osd_save, mem_wr_mon, save_size; cart_flags/cart_region (header, CART_SAVE_HDR_EN only).
module cart_save_upload #(
  parameter int ADDR_W     = 18,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              upload_req,
  input  logic [ADDR_W:0]   save_size,
  input  logic              osd_save,
  input  logic              mem_wr_mon,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  input  logic [15:0]       cart_flags,
  input  logic [7:0]        cart_region
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_next;
  logic [ADDR_W-1:0] r_off;
  logic              r_oor;
  logic              r_upl_d;
  logic              r_dirty;
  logic              r_upload_req;
  logic [7:0]        r_din;

  logic              w_fall;
  logic              w_start;
  logic [24:0]       w_off;
  logic              w_hdr;
  logic              w_hdr_q;
  logic [7:0]        w_hdr_byte;
  logic              w_inrange;

  assign w_fall  = r_upl_d & ~ioctl_upload;
  assign w_start = (r_state == IDLE) & ioctl_rd & ioctl_upload;

`ifdef CART_SAVE_HDR_EN
  logic       r_hdr;
  logic [6:0] r_hidx;

  assign w_hdr   = (ioctl_addr[24:7] == 18'd0);
  assign w_off   = ioctl_addr - 25'd128;
  assign w_hdr_q = r_hdr;

  always_comb begin
    w_hdr_byte = 8'h00;
    unique case (r_hidx)
      7'd0:    w_hdr_byte = 8'h01;
      7'd1:    w_hdr_byte = 8'h41;
      7'd2:    w_hdr_byte = 8'h54;
      7'd3:    w_hdr_byte = 8'h41;
      7'd4:    w_hdr_byte = 8'h52;
      7'd5:    w_hdr_byte = 8'h49;
      7'd53:   w_hdr_byte = cart_flags[15:8];
      7'd54:   w_hdr_byte = cart_flags[7:0];
      7'd57:   w_hdr_byte = cart_region;
      default: w_hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_hdr  <= 1'b0;
      r_hidx <= 7'd0;
    end else if (w_start) begin
      r_hdr  <= w_hdr;
      r_hidx <= ioctl_addr[6:0];
    end
  end
`else
  logic w_unused;

  assign w_hdr      = 1'b0;
  assign w_off      = ioctl_addr;
  assign w_hdr_q    = 1'b0;
  assign w_hdr_byte = 8'h00;
  assign w_unused   = ^{cart_flags, cart_region};
`endif

  // In range only if the offset fits the RAM and is below save_size;
  // a high address bit can never alias back into the payload.
  assign w_inrange = ((w_off >> ADDR_W) == 25'd0) &&
                     (w_off[ADDR_W:0] < save_size);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_start) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT:  if (r_cnt <= 3'd1) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Upload window closing mid-read aborts the read.
    if (w_fall && r_state != IDLE) w_next = IDLE;
  end

  always_comb begin
    w_cnt_next = 3'd0;
    if (w_next == WAIT) begin
      if (r_state == WAIT) w_cnt_next = r_cnt - 3'd1;
      else                 w_cnt_next = 3'(RD_LATENCY);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_off        <= '0;
      r_oor        <= 1'b0;
      r_upl_d      <= 1'b0;
      r_dirty      <= 1'b0;
      r_upload_req <= 1'b0;
      r_din        <= 8'h00;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_upl_d      <= ioctl_upload;
      r_upload_req <= osd_save & r_dirty & ~ioctl_upload;
      if (w_start) begin
        r_off <= w_off[ADDR_W-1:0];
        r_oor <= ~w_hdr & ~w_inrange;
      end
      if (r_state == DONE && !w_fall) begin
        if (w_hdr_q)    r_din <= w_hdr_byte;
        else if (r_oor) r_din <= 8'hFF;
        else            r_din <= mem_q;
      end
      // A write in the same cycle as a clear keeps the data dirty.
      if (mem_wr_mon)
        r_dirty <= 1'b1;
      else if (w_fall && r_state == IDLE)
        r_dirty <= 1'b0;
    end
  end

  assign ioctl_din  = r_din;
  assign ioctl_wait = (r_state != IDLE) | (ioctl_rd & ioctl_upload);
  assign upload_req = r_upload_req;
  assign mem_addr   = r_off;
  assign mem_rd     = (r_state == ISSUE) & ~r_oor & ~w_hdr_q;

endmodule

// File: tb/tb_cart_save_upload.sv
// Bench for cart_save_upload: scoreboarded HPS reads, dirty handshake, abort and reset.
module tb_cart_save_upload;

`ifdef CART_SAVE_HDR_EN
  localparam logic [24:0] H = 25'd128;
`else
  localparam logic [24:0] H = 25'd0;
`endif
  localparam int LAT = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        upload_req;
  logic [18:0] save_size;
  logic        osd_save;
  logic        mem_wr_mon;
  logic [17:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q = 8'h00;
  logic [15:0] cart_flags;
  logic [7:0]  cart_region;

  logic [7:0]  ram [0:1023];
  logic        v1 = 1'b0;
  logic [17:0] a1 = '0;
  logic [7:0]  sb [$];
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk_sys = ~clk_sys;

  cart_save_upload #(.ADDR_W(18), .RD_LATENCY(LAT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .upload_req(upload_req),
    .save_size(save_size), .osd_save(osd_save),
    .mem_wr_mon(mem_wr_mon), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_q(mem_q),
    .cart_flags(cart_flags), .cart_region(cart_region)
  );

  // RAM with two-clock read latency; output holds between reads.
  always @(posedge clk_sys) begin
    v1 <= mem_rd;
    a1 <= mem_addr;
    if (v1) mem_q <= ram[a1[9:0]];
  end

  function automatic logic [7:0] hdr_byte(input logic [6:0] i);
    case (i)
      7'd0:    return 8'h01;
      7'd1:    return "A";
      7'd2:    return "T";
      7'd3:    return "A";
      7'd4:    return "R";
      7'd5:    return "I";
      7'd53:   return cart_flags[15:8];
      7'd54:   return cart_flags[7:0];
      7'd57:   return cart_region;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model(input logic [24:0] a, output logic [7:0] d,
                                output bit hit, output logic [17:0] ma);
    logic [24:0] off;
    d = 8'hFF;
    hit = 1'b0;
    ma = '0;
`ifdef CART_SAVE_HDR_EN
    if (a < 25'd128) begin
      d = hdr_byte(a[6:0]);
      return;
    end
    off = a - 25'd128;
`else
    off = a;
`endif
    if (off < 25'(save_size)) begin
      hit = 1'b1;
      ma = off[17:0];
      d = ram[off[9:0]];
    end
  endfunction

  task automatic do_read(input logic [24:0] a, input bit poke);
    logic [7:0]  exp;
    logic [17:0] ma;
    bit          hit;
    bit          addr_ok;
    int          cyc;
    int          nrd;
    model(a, exp, hit, ma);
    sb.push_back(exp);
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    #1;
    vectors++;
    if (ioctl_wait !== 1'b1) begin
      errors++;
      $display("FAIL wait_comb addr=%h got=%b want=1", a, ioctl_wait);
    end
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    cyc = 0;
    nrd = 0;
    addr_ok = 1'b1;
    while (ioctl_wait === 1'b1 && cyc < 20) begin
      if (mem_rd === 1'b1) begin
        nrd++;
        if (mem_addr !== ma) addr_ok = 1'b0;
      end
      if (poke && cyc == 1) begin
        ioctl_rd = 1'b1;
        ioctl_addr = a ^ 25'h5;
      end else begin
        ioctl_rd = 1'b0;
      end
      cyc++;
      @(negedge clk_sys);
    end
    ioctl_rd = 1'b0;
    vectors++;
    if (cyc != LAT + 2) begin
      errors++;
      $display("FAIL wait_len addr=%h got=%0d want=%0d", a, cyc, LAT + 2);
    end
    vectors++;
    if (nrd != int'(hit) || !addr_ok) begin
      errors++;
      $display("FAIL mem_rd addr=%h pulses=%0d want=%0d addr_ok=%b",
               a, nrd, int'(hit), addr_ok);
    end
    exp = sb.pop_front();
    vectors++;
    if (ioctl_din !== exp) begin
      errors++;
      $display("FAIL din addr=%h got=%h want=%h", a, ioctl_din, exp);
    end
  endtask

  task automatic count_req(output int n);
    osd_save = 1'b1;
    @(negedge clk_sys);
    osd_save = 1'b0;
    n = 0;
    repeat (4) begin
      if (upload_req === 1'b1) n++;
      @(negedge clk_sys);
    end
  endtask

  task automatic check_req(input string name, input int want);
    int n;
    count_req(n);
    vectors++;
    if (n != want) begin
      errors++;
      $display("FAIL %s upload_req pulses got=%0d want=%0d", name, n, want);
    end
  endtask

  task automatic pulse_wr;
    mem_wr_mon = 1'b1;
    @(negedge clk_sys);
    mem_wr_mon = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    osd_save = 1'b1;
    @(negedge clk_sys);
    osd_save = 1'b0;
    @(negedge clk_sys);
    vectors++;
    if ({ioctl_din, ioctl_wait, upload_req, mem_rd} !== 11'd0 ||
        mem_addr !== 18'd0) begin
      errors++;
      $display("FAIL reset din=%h wait=%b req=%b rd=%b addr=%h want all 0",
               ioctl_din, ioctl_wait, upload_req, mem_rd, mem_addr);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    check_req("reset_clean", 0);
  endtask

  task automatic test_idle_ignore;
    bit bad;
    bad = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_addr = H + 25'h10;
    ioctl_rd = 1'b1;
    #1;
    if (ioctl_wait !== 1'b0) bad = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    repeat (4) begin
      if (ioctl_wait !== 1'b0 || mem_rd !== 1'b0) bad = 1'b1;
      @(negedge clk_sys);
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL rd_no_upload got=busy want=idle");
    end
  endtask

  task automatic test_read;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    do_read(H + 25'h10, 1'b0);
  endtask

  task automatic test_oor;
    do_read(H + 25'h100, 1'b0);
    do_read(H + 25'hFF, 1'b0);
    do_read(25'h1000010, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_read(H + 25'h20, 1'b1);
    for (int i = 0; i < 6; i++)
      do_read(H + 25'($urandom_range(0, 'h180)), 1'b0);
  endtask

  task automatic test_dirty;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    pulse_wr();
    check_req("dirty_set", 1);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    do_read(H + 25'h3, 1'b0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check_req("dirty_cleared", 0);
  endtask

  task automatic test_abort;
    logic [7:0] hold;
    bit         bad;
    pulse_wr();
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    do_read(H + 25'h10, 1'b0);
    hold = ram[10'h10];
    ioctl_addr = H + 25'h30;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    bad = 1'b0;
    repeat (4) begin
      if (ioctl_wait !== 1'b0 || ioctl_din !== hold) bad = 1'b1;
      @(negedge clk_sys);
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL abort wait=%b din=%h want wait=0 din=%h",
               ioctl_wait, ioctl_din, hold);
    end
    check_req("abort_dirty_kept", 1);
  endtask

  task automatic test_race;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check_req("race_pre_clear", 0);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    mem_wr_mon = 1'b1;
    @(negedge clk_sys);
    mem_wr_mon = 1'b0;
    @(negedge clk_sys);
    check_req("race_set_wins", 1);
  endtask

  task automatic test_reset_inflight;
    bit bad;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    do_read(H + 25'h10, 1'b0);
    ioctl_addr = H + 25'h11;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      if (ioctl_wait !== 1'b0 || ioctl_din !== 8'h00) bad = 1'b1;
      @(negedge clk_sys);
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL reset_inflight wait=%b din=%h want 0/00",
               ioctl_wait, ioctl_din);
    end
    check_req("reset_clears_dirty", 0);
  endtask

`ifdef CART_SAVE_HDR_EN
  task automatic test_header;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i <= 5; i++) do_read(25'(i), 1'b0);
    do_read(25'd53, 1'b0);
    do_read(25'd54, 1'b0);
    do_read(25'd57, 1'b0);
    do_read(25'd60, 1'b0);
    do_read(25'd128, 1'b0);
    do_read(25'd127, 1'b0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd = 1'b0;
    ioctl_addr = '0;
    save_size = 19'h100;
    osd_save = 1'b0;
    mem_wr_mon = 1'b0;
    cart_flags = 16'h1234;
    cart_region = 8'h5A;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
    ram[10'h10] = 8'hA5;
    test_reset();
    test_idle_ignore();
    test_read();
    test_oor();
    test_back_to_back();
    test_dirty();
    test_abort();
    test_race();
    test_reset_inflight();
`ifdef CART_SAVE_HDR_EN
    test_header();
`endif
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cart_save_upload.md
CART_SAVE_UPLOAD -- requirements
Module: cart_save_upload

Interface
REQ-001 SHALL have parameter ADDR_W, default 18: save-RAM address width.
REQ-002 SHALL have parameter RD_LATENCY, default 2: RAM read latency in clocks; legal range 1..4.
REQ-003 SHALL have port clk_sys, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port ioctl_upload, input, 1: the HPS upload window is open.
REQ-006 SHALL have port ioctl_rd, input, 1: one-cycle HPS byte-read strobe.
REQ-007 SHALL have port ioctl_addr, input, 25: byte offset requested by the HPS.
REQ-008 SHALL have port ioctl_din, output, 8: byte returned to the HPS.
REQ-009 SHALL have port ioctl_wait, output, 1: tells the HPS to hold off.
REQ-010 SHALL have port upload_req, output, 1: one-cycle pulse asking the HPS to start an upload.
REQ-011 SHALL have port save_size, input, ADDR_W+1: number of valid payload bytes.
REQ-012 SHALL have port osd_save, input, 1: one-cycle save command from the OSD.
REQ-013 SHALL have port mem_wr_mon, input, 1: the core wrote to save RAM this cycle.
REQ-014 SHALL have port mem_addr, output, ADDR_W: save-RAM read address.
REQ-015 SHALL have port mem_rd, output, 1: save-RAM read enable.
REQ-016 SHALL have port mem_q, input, 8: save-RAM read data.
REQ-017 SHALL have port cart_flags, input, 16: header bytes 53..54, used only when CART_SAVE_HDR_EN is defined.
REQ-018 SHALL have port cart_region, input, 8: header byte 57, used only when CART_SAVE_HDR_EN is defined.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, ISSUE, WAIT and DONE.
REQ-020 In IDLE, ioctl_rd=1 with ioctl_upload=1 SHALL latch ioctl_addr and move to ISSUE.
REQ-021 ioctl_wait SHALL equal (state != IDLE) OR (ioctl_rd AND ioctl_upload), combinationally.
REQ-022 ISSUE SHALL last one cycle and assert mem_rd=1 with mem_addr equal to the payload offset; mem_rd SHALL be 0 in every other state.
REQ-023 WAIT SHALL last exactly RD_LATENCY cycles, counted by a down-counter.
REQ-024 DONE SHALL register ioctl_din from mem_q and return to IDLE; ioctl_wait SHALL therefore drop RD_LATENCY+2 cycles after the ioctl_rd cycle.
REQ-025 A payload offset >= save_size SHALL NOT assert mem_rd and SHALL return 0xFF with the same timing as an in-range read.
REQ-026 An ioctl_rd outside IDLE SHALL be ignored.
REQ-027 An ioctl_rd while ioctl_upload=0 SHALL be ignored.
REQ-028 ioctl_din SHALL hold its last value until the next completed read.
REQ-029 A dirty flag SHALL be set by mem_wr_mon=1.
REQ-030 osd_save=1 with dirty=1 and ioctl_upload=0 SHALL produce a single upload_req pulse on the next cycle.
REQ-031 osd_save with dirty=0 SHALL NOT pulse upload_req.
REQ-032 On the falling edge of ioctl_upload with the FSM in IDLE, dirty SHALL be cleared.
REQ-033 On the falling edge of ioctl_upload with the FSM outside IDLE, the FSM SHALL abort to IDLE, ioctl_din SHALL be unchanged, and dirty SHALL be kept.
REQ-034 When mem_wr_mon and a dirty clear occur in the same cycle, the set SHALL win.
REQ-035 Offset arithmetic SHALL use ADDR_W+1 bits with no wrap; any ioctl_addr bits above the payload range SHALL make the offset out-of-range (REQ-025).

Reset
REQ-036 On reset_n=0 at a clock edge: state=IDLE, ioctl_din=0x00, ioctl_wait=0, upload_req=0, mem_rd=0, mem_addr=0, dirty=0, WAIT counter=0.
REQ-037 Reset SHALL take precedence over every other event, including a read in flight.

Configuration
REQ-038 Macro CART_SAVE_HDR_EN defined: offsets 0..127 SHALL return a synthesized A78 header and SHALL NOT access RAM.
- Header bytes: byte 0 = 0x01; bytes 1..5 = "ATARI"; byte 53 = cart_flags[15:8]; byte 54 = cart_flags[7:0]; byte 57 = cart_region; all other bytes 0x00.
- Payload offset = ioctl_addr-128; total readable length = save_size+128.
- Header bytes SHALL use the same ISSUE/WAIT/DONE timing as payload bytes.
REQ-039 Macro CART_SAVE_HDR_EN undefined: payload offset = ioctl_addr; no header logic SHALL be generated; cart_flags and cart_region SHALL be unused.

Verification
REQ-040 Reset and idle: after reset, hold reset_n=0 for 2 cycles -> all outputs 0; no upload_req pulse on osd_save.
REQ-041 Basic read (RD_LATENCY=2, macro off): RAM[0x10]=0xA5, save_size=0x100, ioctl_rd at addr 0x10 -> mem_rd pulse with mem_addr=0x10; ioctl_wait high for 4 cycles; then ioctl_din=0xA5.
REQ-042 Out-of-range read: addr 0x100 with save_size=0x100 -> mem_rd stays 0; ioctl_din=0xFF with the same wait length as REQ-041.
REQ-043 Dirty handshake:
- mem_wr_mon pulse, then osd_save -> exactly one upload_req pulse.
- Complete the upload, drop ioctl_upload -> dirty cleared.
- Second osd_save -> no upload_req pulse.
REQ-044 Abort and races:
- Drop ioctl_upload in the WAIT state -> FSM returns to IDLE, ioctl_din unchanged, dirty kept.
- mem_wr_mon on the same cycle as a dirty clear -> dirty=1.
REQ-045 Header mode (macro on):
- Reads at 1..5 -> "ATARI".
- Read at 53 with cart_flags=0x1234 -> 0x12.
- Read at 128 -> RAM[0].
